apb_intc: RTL

- APB-programmable interrupt controller; sits directly downstream of the timer and other APB peripherals.
- Collects their int_o lines on src_i and latches them into pending bits, with edge or level capture per source.
- Masks pending bits with a per-source enable and drives a single registered irq_o to the CPU.
- Exposes the lowest-numbered active source as a claim ID.
- Shares the same 4-bit APB slave port style as the other peripherals on the bus.

---
 rtl/apb_intc.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/apb_intc.sv
// apb_intc: APB-programmable interrupt controller.
//
// Collects NUM_SRC active-high request lines into per-source pending bits
// (edge or level capture per source), masks them with a per-source enable,
// drives one registered interrupt request and exposes the lowest-numbered
// active source as a claim ID.
//
// Ports:
//   apb_pclk     clock, rising edge
//   apb_prst     synchronous active-high reset
//   apb_psel     APB select
//   apb_paddr    4-bit register byte address
//   apb_pwrite   1 = write, 0 = read
//   apb_penable  APB access phase
//   apb_pwdata   32-bit write data
//   apb_prdata   32-bit read data (combinational, 0 unless reading)
//   src_i        interrupt request lines, bit 0 is the timer
//   irq_o        registered interrupt request to the CPU
//
// Register map (full 4-bit decode):
//   0x0 ENABLE  RW
//   0x4 MODE    RW   1 = edge capture, 0 = level capture
//   0x8 PENDING R, W1C (a coincident set wins over the clear)
//   0xC CLAIM   RO   bit31 = any_active, bits[4:0] = lowest active id

module apb_intc #(
    parameter int unsigned NUM_SRC = 8,
    parameter bit          SYNC_EN = 1'b0
) (
    input  logic               apb_pclk,
    input  logic               apb_prst,
    input  logic               apb_psel,
    input  logic [3:0]         apb_paddr,
    input  logic               apb_pwrite,
    input  logic               apb_penable,
    input  logic [31:0]        apb_pwdata,
    output logic [31:0]        apb_prdata,
    input  logic [NUM_SRC-1:0] src_i,
    output logic               irq_o
);

    localparam logic [3:0] ADDR_ENABLE  = 4'h0;
    localparam logic [3:0] ADDR_MODE    = 4'h4;
    localparam logic [3:0] ADDR_PENDING = 4'h8;
    localparam logic [3:0] ADDR_CLAIM   = 4'hC;

    logic               we;
    logic               re;
    logic [NUM_SRC-1:0] s;
    logic [NUM_SRC-1:0] s_q;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] mode_q, mode_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic               irq_q, irq_d;
    logic [NUM_SRC-1:0] set;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] active;
    logic               any_active;
    logic [4:0]         claim_id;
    logic               claim_found;
    logic [31:0]        rdata;
    // Write-data bits above NUM_SRC are legitimately ignored.
    logic               unused_pwdata;

    assign we            = apb_psel & apb_penable & apb_pwrite;
    assign re            = apb_psel & apb_penable & ~apb_pwrite;
    assign unused_pwdata = ^apb_pwdata;

    // Optional two-flop synchronizer for asynchronous sources.
    if (SYNC_EN) begin : g_sync
        logic [NUM_SRC-1:0] sync1_q;
        logic [NUM_SRC-1:0] sync2_q;

        always_ff @(posedge apb_pclk) begin
            if (apb_prst) begin
                sync1_q <= '0;
                sync2_q <= '0;
            end else begin
                sync1_q <= src_i;
                sync2_q <= sync1_q;
            end
        end

        assign s = sync2_q;
    end else begin : g_direct
        assign s = src_i;
    end

    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        w1c      = '0;

        if (we) begin
            case (apb_paddr)
                ADDR_ENABLE:  enable_d = apb_pwdata[NUM_SRC-1:0];
                ADDR_MODE:    mode_d   = apb_pwdata[NUM_SRC-1:0];
                ADDR_PENDING: w1c      = apb_pwdata[NUM_SRC-1:0];
                default:      ;
            endcase
        end

        // Edge sources set on a rising sample, level sources whenever high.
        set       = (mode_q & s & ~s_q) | (~mode_q & s);
        pending_d = set | (pending_q & ~w1c);

        active     = pending_q & enable_q;
        any_active = |active;
        irq_d      = any_active;
    end

    // Lowest-numbered active source wins; id stays 0 when nothing is active.
    always_comb begin
        claim_id    = '0;
        claim_found = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (active[i] && !claim_found) begin
                claim_id    = 5'(i);
                claim_found = 1'b1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (apb_paddr)
            ADDR_ENABLE:  rdata[NUM_SRC-1:0] = enable_q;
            ADDR_MODE:    rdata[NUM_SRC-1:0] = mode_q;
            ADDR_PENDING: rdata[NUM_SRC-1:0] = pending_q;
            ADDR_CLAIM: begin
                rdata[31]  = any_active;
                rdata[4:0] = claim_id;
            end
            default:      ;
        endcase
        apb_prdata = re ? rdata : '0;
    end

    always_ff @(posedge apb_pclk) begin
        if (apb_prst) begin
            s_q       <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            s_q       <= s;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    assign irq_o = irq_q;

endmodule
